ram_ecc_scrubber: RTL and testbench
===================================

Name: ram_ecc_scrubber

Overview:
- Companion controller for the 128x20 ECC two-port RAM wrapper.
- Sits between the RAM and its client. Passes client reads and writes through with priority.
- In idle cycles it reads every location in turn and watches SB_CORRECT/DB_DETECT. It writes the corrected word back on a single-bit error and logs double-bit errors.
- Prevents single-bit upsets from piling up into uncorrectable errors.

Parameters:
- ADDR_WIDTH, 7, RAM address width.
- DATA_WIDTH, 20, RAM word width.
- DEPTH, 128, number of locations scrubbed; the address wraps at DEPTH-1.
- SCRUB_INTERVAL, 1024, idle cycles between scrub reads (minimum 1).
- CNT_WIDTH, 8, width of the saturating error counters.

Ports:
- CLK  in  1  single clock for the block and the RAM.
- RST  in  1  asynchronous, active-high reset.
- CL_WEN  in  1  client write enable.
- CL_WADDR  in  ADDR_WIDTH  client write address.
- CL_WD  in  DATA_WIDTH  client write data.
- CL_REN  in  1  client read request; the client owns the RAM read port this cycle.
- CL_RADDR  in  ADDR_WIDTH  client read address.
- CL_RD  out  DATA_WIDTH  equals RAM_RD; valid 1 cycle after a CL_REN cycle.
- RAM_WEN  out  1  to RAM WEN.
- RAM_WADDR  out  ADDR_WIDTH  to RAM WADDR.
- RAM_WD  out  DATA_WIDTH  to RAM WD.
- RAM_RADDR  out  ADDR_WIDTH  to RAM RADDR.
- RAM_RD  in  DATA_WIDTH  from RAM RD (already corrected).
- RAM_SB  in  1  from RAM SB_CORRECT.
- RAM_DB  in  1  from RAM DB_DETECT.
- SCRUB_EN  in  1  enables scrubbing; 0 holds the FSM in IDLE.
- ERR_CLR  in  1  synchronous clear of the counters and DB_FLAG.
- SB_CNT  out  CNT_WIDTH  single-bit errors corrected (saturating).
- DB_CNT  out  CNT_WIDTH  double-bit errors detected (saturating).
- DB_FLAG  out  1  sticky; set on a double-bit error.
- DB_ADDR  out  ADDR_WIDTH  address of the most recent double-bit error.

Behaviour:
- Reset values:
  - state IDLE; scrub_addr 0; interval counter 0.
  - SB_CNT 0; DB_CNT 0; DB_FLAG 0; DB_ADDR 0.
  - RAM_WEN 0; RAM_WADDR 0; RAM_RADDR 0; RAM_WD 0.
- RAM read latency is 1 cycle: data and flags for an address issued in cycle T appear in T+1.
- The RAM forces flags to 0 in T+1 if WEN was high in T.
- Write port mux: CL_WEN=1 passes the client write through combinationally. Otherwise, in WB with the slot free, the scrubber drives RAM_WEN=1, RAM_WADDR=scrub_addr, RAM_WD=wb_data.
- Read port mux: RAM_RADDR = CL_RADDR when CL_REN=1, else scrub_addr.
- FSM states: IDLE, WAIT, READ, CHECK, WB.
  - IDLE: if SCRUB_EN, go to WAIT and load the counter with SCRUB_INTERVAL-1.
  - WAIT: decrement the counter; at 0, go to READ. SCRUB_EN=0 returns to IDLE from any state except WB; WB always completes or aborts first.
  - READ: if CL_REN=1, stall in READ. Otherwise the scrub address is issued this cycle; record wen_at_read = CL_WEN, then go to CHECK.
  - CHECK: sample RAM_RD, RAM_SB, RAM_DB.
    - If wen_at_read=1, the flags are masked: retry in READ without advancing.
    - DB=1: DB_CNT+1 (saturating), DB_FLAG=1, DB_ADDR=scrub_addr. Advance without writeback, since the data is unrecoverable. Go to WAIT.
    - SB=1: wb_data=RAM_RD, SB_CNT+1, go to WB.
    - Neither flag: advance, go to WAIT.
  - WB:
    - If CL_WEN=1 with CL_WADDR==scrub_addr (now or in any cycle since the read), abort the writeback; the client data is fresh. Advance, go to WAIT.
    - If CL_WEN=1 with another address, stall in WB.
    - Else write wb_data, advance, go to WAIT.
- Advance means scrub_addr = scrub_addr+1, wrapping from DEPTH-1 to 0.
- Counters saturate at all-ones.
- ERR_CLR clears SB_CNT, DB_CNT and DB_FLAG; DB_ADDR is kept.
- Simultaneous ERR_CLR and a count/set event: clear takes priority; that event is lost.
- Reset asserted mid-WB: no write issues, all state returns to reset values.

Decomposition:
- Shared package holds:
  - the FSM state enum (IDLE/WAIT/READ/CHECK/WB);
  - the RAM geometry constants (depth 128, width 20, read latency 1).
- One natural sub-module: ecc_sat_counter (parameterised width, inc, clr, saturate); instantiated twice for SB_CNT and DB_CNT.
- The port mux and FSM stay in the top-level module.

Test Plan:
- SCRUB_INTERVAL=4, no client traffic, no errors → RAM_RADDR sweeps 0..127 then wraps to 0; one read every 5 cycles; SB_CNT=DB_CNT=0.
- Force RAM_SB=1 in the CHECK cycle at addr 9 with RAM_RD=20'h5A5A5 → next cycle RAM_WEN=1, RAM_WADDR=9, RAM_WD=20'h5A5A5; SB_CNT=1.
- Force RAM_DB=1 at addr 100 → DB_FLAG=1, DB_ADDR=100, DB_CNT=1, no RAM_WEN pulse; then ERR_CLR → counters 0, DB_FLAG 0, DB_ADDR stays 100.
- Single-bit error at addr 9 plus client write to addr 9 in the WB cycle → only the client write occurs (RAM_WD=CL_WD); scrub_addr advances to 10. With the client write to addr 3 instead → WB stalls one cycle, then the scrub write to 9.
- CL_REN held high 10 cycles while the FSM is in READ → RAM_RADDR follows CL_RADDR; the scrub read issues the first cycle after CL_REN falls.
- Client write in the scrub READ cycle → CHECK discards the sample and retries the same address; counters unchanged. Reset asserted in WB → no write; all outputs 0.

Source files
------------

// File: rtl/ram_ecc_scrubber_pkg.sv
// Shared types and RAM geometry for the ECC scrubber controller.
package ram_ecc_scrubber_pkg;

    localparam int RAM_DEPTH  = 128;
    localparam int RAM_WIDTH  = 20;
    localparam int RAM_RD_LAT = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_READ,
        S_CHECK,
        S_WB
    } scrub_state_e;

endpackage

// File: rtl/ram_ecc_scrubber_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module ecc_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != '1))
            cnt_d = cnt_q + WIDTH'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ram_ecc_scrubber.sv
// Background ECC scrubber: muxes client traffic onto the RAM ports and, in idle
// cycles, walks every word, rewriting corrected data and logging uncorrectable ones.
module ram_ecc_scrubber
    import ram_ecc_scrubber_pkg::*;
#(
    parameter int ADDR_WIDTH     = 7,
    parameter int DATA_WIDTH     = RAM_WIDTH,
    parameter int DEPTH          = RAM_DEPTH,
    parameter int SCRUB_INTERVAL = 1024,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CL_WEN,
    input  logic [ADDR_WIDTH-1:0] CL_WADDR,
    input  logic [DATA_WIDTH-1:0] CL_WD,
    input  logic                  CL_REN,
    input  logic [ADDR_WIDTH-1:0] CL_RADDR,
    output logic [DATA_WIDTH-1:0] CL_RD,
    output logic                  RAM_WEN,
    output logic [ADDR_WIDTH-1:0] RAM_WADDR,
    output logic [DATA_WIDTH-1:0] RAM_WD,
    output logic [ADDR_WIDTH-1:0] RAM_RADDR,
    input  logic [DATA_WIDTH-1:0] RAM_RD,
    input  logic                  RAM_SB,
    input  logic                  RAM_DB,
    input  logic                  SCRUB_EN,
    input  logic                  ERR_CLR,
    output logic [CNT_WIDTH-1:0]  SB_CNT,
    output logic [CNT_WIDTH-1:0]  DB_CNT,
    output logic                  DB_FLAG,
    output logic [ADDR_WIDTH-1:0] DB_ADDR
);

    localparam int                    IW        = $clog2(SCRUB_INTERVAL + 1);
    localparam logic [IW-1:0]         IV_LOAD   = IW'(SCRUB_INTERVAL - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    scrub_state_e          state_q, state_d;
    logic [IW-1:0]         ivl_q, ivl_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_nxt;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
    logic                  wen_rd_q, wen_rd_d;
    logic                  hit_q, hit_d;
    logic                  db_flag_q, db_flag_d;
    logic [ADDR_WIDTH-1:0] db_addr_q, db_addr_d;
    logic                  sb_evt, db_evt, wb_fire, cl_hit;

    assign addr_nxt = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_WIDTH'(1);
    assign cl_hit   = CL_WEN && (CL_WADDR == addr_q);

    always_comb begin
        state_d   = state_q;
        ivl_d     = ivl_q;
        addr_d    = addr_q;
        wb_data_d = wb_data_q;
        wen_rd_d  = wen_rd_q;
        hit_d     = hit_q;
        sb_evt    = 1'b0;
        db_evt    = 1'b0;
        wb_fire   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (SCRUB_EN) begin
                    state_d = S_WAIT;
                    ivl_d   = IV_LOAD;
                end
            end
            S_WAIT: begin
                if (!SCRUB_EN)
                    state_d = S_IDLE;
                else if (ivl_q <= IW'(1))
                    state_d = S_READ;
                else
                    ivl_d = ivl_q - IW'(1);
            end
            S_READ: begin
                if (!SCRUB_EN) begin
                    state_d = S_IDLE;
                end else if (!CL_REN) begin
                    // A same-cycle write zeroes the RAM flags, so remember to retry.
                    wen_rd_d = CL_WEN;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!SCRUB_EN) begin
                    state_d = S_IDLE;
                end else if (wen_rd_q) begin
                    state_d = S_READ;
                end else if (RAM_DB) begin
                    db_evt  = 1'b1;
                    addr_d  = addr_nxt;
                    state_d = S_WAIT;
                    ivl_d   = IV_LOAD;
                end else if (RAM_SB) begin
                    sb_evt    = 1'b1;
                    wb_data_d = RAM_RD;
                    hit_d     = cl_hit;
                    state_d   = S_WB;
                end else begin
                    addr_d  = addr_nxt;
                    state_d = S_WAIT;
                    ivl_d   = IV_LOAD;
                end
            end
            S_WB: begin
                // Client data written since the read is newer than our copy: drop ours.
                if (hit_q || cl_hit) begin
                    addr_d  = addr_nxt;
                    state_d = S_WAIT;
                    ivl_d   = IV_LOAD;
                end else if (!CL_WEN) begin
                    wb_fire = 1'b1;
                    addr_d  = addr_nxt;
                    state_d = S_WAIT;
                    ivl_d   = IV_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        db_flag_d = db_flag_q;
        db_addr_d = db_addr_q;
        if (ERR_CLR) begin
            db_flag_d = 1'b0;
        end else if (db_evt) begin
            db_flag_d = 1'b1;
            db_addr_d = addr_q;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            ivl_q     <= '0;
            addr_q    <= '0;
            wb_data_q <= '0;
            wen_rd_q  <= 1'b0;
            hit_q     <= 1'b0;
            db_flag_q <= 1'b0;
            db_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            ivl_q     <= ivl_d;
            addr_q    <= addr_d;
            wb_data_q <= wb_data_d;
            wen_rd_q  <= wen_rd_d;
            hit_q     <= hit_d;
            db_flag_q <= db_flag_d;
            db_addr_q <= db_addr_d;
        end
    end

    ecc_sat_counter #(.WIDTH(CNT_WIDTH)) u_sb_cnt (
        .clk_i (CLK),
        .rst_i (RST),
        .inc_i (sb_evt),
        .clr_i (ERR_CLR),
        .cnt_o (SB_CNT)
    );

    ecc_sat_counter #(.WIDTH(CNT_WIDTH)) u_db_cnt (
        .clk_i (CLK),
        .rst_i (RST),
        .inc_i (db_evt),
        .clr_i (ERR_CLR),
        .cnt_o (DB_CNT)
    );

    assign RAM_WEN   = CL_WEN | wb_fire;
    assign RAM_WADDR = CL_WEN ? CL_WADDR : addr_q;
    assign RAM_WD    = CL_WEN ? CL_WD : wb_data_q;
    assign RAM_RADDR = CL_REN ? CL_RADDR : addr_q;
    assign CL_RD     = RAM_RD;
    assign DB_FLAG   = db_flag_q;
    assign DB_ADDR   = db_addr_q;

endmodule

// File: tb/tb_ram_ecc_scrubber.sv
// Directed bench for ram_ecc_scrubber with a 1-cycle-latency RAM stand-in that injects ECC flags.
module tb_ram_ecc_scrubber;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CL_WEN;
    logic [6:0]  CL_WADDR;
    logic [19:0] CL_WD;
    logic        CL_REN;
    logic [6:0]  CL_RADDR;
    logic [19:0] CL_RD;
    logic        RAM_WEN;
    logic [6:0]  RAM_WADDR;
    logic [19:0] RAM_WD;
    logic [6:0]  RAM_RADDR;
    logic [19:0] RAM_RD;
    logic        RAM_SB;
    logic        RAM_DB;
    logic        SCRUB_EN;
    logic        ERR_CLR;
    logic [3:0]  SB_CNT;
    logic [3:0]  DB_CNT;
    logic        DB_FLAG;
    logic [6:0]  DB_ADDR;

    int errors = 0;
    int checks = 0;
    int wen_cnt = 0;
    logic [6:0] last_ra;

    // RAM stand-in: flags for the captured address, forced low after a write cycle.
    logic [6:0]  rd_a;
    logic        wen_q;
    logic        inj_sb, inj_db, inj_all;
    logic [6:0]  inj_addr;
    logic [19:0] inj_data;
    logic        hitm;

    always #5 CLK = ~CLK;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_a  <= '0;
            wen_q <= 1'b0;
        end else begin
            rd_a  <= RAM_RADDR;
            wen_q <= RAM_WEN;
        end
    end

    always @(posedge CLK) if (RAM_WEN) wen_cnt <= wen_cnt + 1;

    assign hitm   = !wen_q && (inj_all || (rd_a == inj_addr));
    assign RAM_SB = inj_sb && hitm;
    assign RAM_DB = inj_db && hitm;
    assign RAM_RD = (inj_sb && hitm) ? inj_data : {13'h0, rd_a};

    ram_ecc_scrubber #(
        .ADDR_WIDTH(7), .DATA_WIDTH(20), .DEPTH(128), .SCRUB_INTERVAL(4), .CNT_WIDTH(4)
    ) dut (
        .CLK(CLK), .RST(RST),
        .CL_WEN(CL_WEN), .CL_WADDR(CL_WADDR), .CL_WD(CL_WD),
        .CL_REN(CL_REN), .CL_RADDR(CL_RADDR), .CL_RD(CL_RD),
        .RAM_WEN(RAM_WEN), .RAM_WADDR(RAM_WADDR), .RAM_WD(RAM_WD), .RAM_RADDR(RAM_RADDR),
        .RAM_RD(RAM_RD), .RAM_SB(RAM_SB), .RAM_DB(RAM_DB),
        .SCRUB_EN(SCRUB_EN), .ERR_CLR(ERR_CLR),
        .SB_CNT(SB_CNT), .DB_CNT(DB_CNT), .DB_FLAG(DB_FLAG), .DB_ADDR(DB_ADDR)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_change(output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (RAM_RADDR == last_ra && n < 100);
        chk("addr_change_seen", 32'(RAM_RADDR != last_ra), 1);
        last_ra = RAM_RADDR;
    endtask

    // Returns on the first cycle the scrub address shows t (the first wait cycle).
    task automatic wait_addr(input logic [6:0] t);
        int n;
        bit found;
        n = 0;
        found = 1'b0;
        last_ra = RAM_RADDR;
        do begin
            @(negedge CLK);
            n++;
            found = (RAM_RADDR == t) && (last_ra != t);
            last_ra = RAM_RADDR;
        end while (!found && n < 2000);
        chk("reach_addr", 32'(found), 1);
    endtask

    initial begin
        int n;
        int wc;
        RST = 1'b1; CL_WEN = 1'b0; CL_WADDR = '0; CL_WD = '0; CL_REN = 1'b0; CL_RADDR = '0;
        SCRUB_EN = 1'b0; ERR_CLR = 1'b0;
        inj_sb = 1'b0; inj_db = 1'b0; inj_all = 1'b0; inj_addr = '0; inj_data = '0;
        repeat (2) @(negedge CLK);
        chk("rst_wen",    32'(RAM_WEN), 0);
        chk("rst_waddr",  32'(RAM_WADDR), 0);
        chk("rst_raddr",  32'(RAM_RADDR), 0);
        chk("rst_wd",     32'(RAM_WD), 0);
        chk("rst_sbcnt",  32'(SB_CNT), 0);
        chk("rst_dbcnt",  32'(DB_CNT), 0);
        chk("rst_dbflag", 32'(DB_FLAG), 0);
        chk("rst_dbaddr", 32'(DB_ADDR), 0);

        // Full sweep with wrap, one read every 5 cycles.
        RST = 1'b0; SCRUB_EN = 1'b1;
        last_ra = RAM_RADDR;
        wait_change(n);
        chk("first_adv", 32'(RAM_RADDR), 1);
        for (int i = 2; i <= 128; i++) begin
            wait_change(n);
            chk("sweep_addr", 32'(RAM_RADDR), i % 128);
            chk("sweep_gap", n, 5);
        end
        chk("sweep_sbcnt", 32'(SB_CNT), 0);
        chk("sweep_dbcnt", 32'(DB_CNT), 0);

        // Single-bit error at 9: writeback the cycle after CHECK.
        inj_sb = 1'b1; inj_addr = 7'd9; inj_data = 20'h5A5A5;
        wait_addr(7'd9);
        repeat (4) @(negedge CLK);
        chk("chk_no_wen", 32'(RAM_WEN), 0);
        @(negedge CLK);
        chk("wb_wen",   32'(RAM_WEN), 1);
        chk("wb_waddr", 32'(RAM_WADDR), 9);
        chk("wb_wd",    32'(RAM_WD), 'h5A5A5);
        chk("wb_sbcnt", 32'(SB_CNT), 1);
        inj_sb = 1'b0;
        @(negedge CLK);
        chk("wb_done_wen", 32'(RAM_WEN), 0);
        chk("wb_adv",      32'(RAM_RADDR), 10);

        // Double-bit error at 100: logged, no writeback, then cleared.
        inj_db = 1'b1; inj_addr = 7'd100;
        wc = wen_cnt;
        wait_addr(7'd100);
        repeat (5) @(negedge CLK);
        chk("db_flag",  32'(DB_FLAG), 1);
        chk("db_addr",  32'(DB_ADDR), 100);
        chk("db_cnt",   32'(DB_CNT), 1);
        chk("db_sbcnt", 32'(SB_CNT), 1);
        chk("db_adv",   32'(RAM_RADDR), 101);
        chk("db_no_wb", wen_cnt, wc);
        inj_db = 1'b0;
        ERR_CLR = 1'b1;
        @(negedge CLK);
        ERR_CLR = 1'b0;
        chk("clr_sbcnt",  32'(SB_CNT), 0);
        chk("clr_dbcnt",  32'(DB_CNT), 0);
        chk("clr_dbflag", 32'(DB_FLAG), 0);
        chk("clr_dbaddr", 32'(DB_ADDR), 100);

        // Client write to the scrub address during WB aborts the writeback.
        inj_sb = 1'b1; inj_addr = 7'd9; inj_data = 20'h5A5A5;
        wait_addr(7'd9);
        repeat (5) @(negedge CLK);
        chk("abort_pre_wen", 32'(RAM_WEN), 1);
        CL_WEN = 1'b1; CL_WADDR = 7'd9; CL_WD = 20'hC0FFE;
        #1;
        chk("abort_cl_wen",   32'(RAM_WEN), 1);
        chk("abort_cl_waddr", 32'(RAM_WADDR), 9);
        chk("abort_cl_wd",    32'(RAM_WD), 'hC0FFE);
        @(posedge CLK); #1;
        CL_WEN = 1'b0; inj_sb = 1'b0;
        @(negedge CLK);
        chk("abort_no_wen", 32'(RAM_WEN), 0);
        chk("abort_adv",    32'(RAM_RADDR), 10);
        chk("abort_sbcnt",  32'(SB_CNT), 1);

        // Client write elsewhere during WB stalls the writeback one cycle.
        inj_sb = 1'b1; inj_addr = 7'd9; inj_data = 20'h5A5A5;
        wait_addr(7'd9);
        repeat (5) @(negedge CLK);
        CL_WEN = 1'b1; CL_WADDR = 7'd3; CL_WD = 20'h11111;
        #1;
        chk("stall_cl_waddr", 32'(RAM_WADDR), 3);
        chk("stall_cl_wd",    32'(RAM_WD), 'h11111);
        @(posedge CLK); #1;
        CL_WEN = 1'b0; inj_sb = 1'b0;
        @(negedge CLK);
        chk("stall_wb_wen",   32'(RAM_WEN), 1);
        chk("stall_wb_waddr", 32'(RAM_WADDR), 9);
        chk("stall_wb_wd",    32'(RAM_WD), 'h5A5A5);
        @(negedge CLK);
        chk("stall_done_wen", 32'(RAM_WEN), 0);
        chk("stall_adv",      32'(RAM_RADDR), 10);
        chk("stall_sbcnt",    32'(SB_CNT), 2);

        // Client read held 10 cycles while the scrubber sits in READ.
        wait_addr(7'd20);
        repeat (3) @(negedge CLK);
        CL_REN = 1'b1; CL_RADDR = 7'd77;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("cl_raddr", 32'(RAM_RADDR), 77);
            @(negedge CLK);
        end
        chk("cl_rd", 32'(CL_RD), 77);
        CL_REN = 1'b0;
        #1;
        chk("scrub_issue", 32'(RAM_RADDR), 20);
        @(negedge CLK);
        chk("scrub_rd",    32'(CL_RD), 20);
        @(negedge CLK);
        chk("scrub_after", 32'(RAM_RADDR), 21);

        // Client write during the scrub READ forces a retry of the same address.
        wait_addr(7'd30);
        repeat (3) @(negedge CLK);
        CL_WEN = 1'b1; CL_WADDR = 7'd50; CL_WD = 20'hABCDE;
        @(posedge CLK); #1;
        CL_WEN = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("retry_same", 32'(RAM_RADDR), 30);
        repeat (2) @(negedge CLK);
        chk("retry_adv",   32'(RAM_RADDR), 31);
        chk("retry_sbcnt", 32'(SB_CNT), 2);
        chk("retry_dbcnt", 32'(DB_CNT), 0);

        // Every word single-bit: counter saturates, then clear collides with an increment.
        inj_all = 1'b1; inj_sb = 1'b1; inj_data = 20'h12345;
        last_ra = RAM_RADDR;
        for (int i = 0; i < 20; i++) wait_change(n);
        chk("sb_sat", 32'(SB_CNT), 15);
        repeat (4) @(negedge CLK);
        ERR_CLR = 1'b1;
        @(negedge CLK);
        ERR_CLR = 1'b0;
        chk("clr_priority", 32'(SB_CNT), 0);
        chk("sat_wb_wen",   32'(RAM_WEN), 1);
        chk("sat_wb_wd",    32'(RAM_WD), 'h12345);

        // Reset during WB: write withdrawn, everything back to reset values.
        wc = wen_cnt;
        RST = 1'b1;
        #1;
        chk("rwb_wen",    32'(RAM_WEN), 0);
        chk("rwb_waddr",  32'(RAM_WADDR), 0);
        chk("rwb_raddr",  32'(RAM_RADDR), 0);
        chk("rwb_wd",     32'(RAM_WD), 0);
        chk("rwb_sbcnt",  32'(SB_CNT), 0);
        chk("rwb_dbcnt",  32'(DB_CNT), 0);
        chk("rwb_dbflag", 32'(DB_FLAG), 0);
        chk("rwb_dbaddr", 32'(DB_ADDR), 0);
        inj_all = 1'b0; inj_sb = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rwb_no_write", wen_cnt, wc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
